stopwatch_counter: RTL
======================

# stopwatch_counter

Timekeeping datapath driven by the stopwatch control FSM. It consumes the FSM's enable and clear strobes and counts elapsed time as six BCD digits (MM:SS.hh) from a prescaled system clock. It sits between the control FSM and the display driver, and supplies the time value, a tick strobe and a sticky overflow flag.

## Interface
- `TICK_DIV`, default 1000000: clkIn cycles per hundredth of a second; legal range ≥ 1.
- `clkIn`  input  1  system clock; all state changes on the rising edge.
- `rstIn`  input  1  asynchronous, active-high reset.
- `enCounterIn`  input  1  count enable, driven by the FSM's enCounterOut; level-sensitive.
- `clrCounterIn`  input  1  synchronous clear, driven by the FSM's clrCounterOut; level-sensitive.
- `lapIn`  input  1  lap toggle pulse, one cycle wide. Used only when the lap feature is compiled in; ignored otherwise.
- `timeOut`  output  24  displayed time, BCD packed:
  - [23:20] min tens, 0–5
  - [19:16] min ones, 0–9
  - [15:12] sec tens, 0–5
  - [11:8] sec ones, 0–9
  - [7:4] hundredths tens, 0–9
  - [3:0] hundredths ones, 0–9
- `tickOut`  output  1  one-cycle pulse on each hundredth increment.
- `overflowOut`  output  1  sticky; set when 59:59.99 wraps to 00:00.00.

## Operation
- **Reset.** Assertion of rstIn sets these immediately, independent of clkIn: all digits 0, prescaler 0, timeOut=0, tickOut=0, overflowOut=0, lap state LIVE.
- **Priority per edge.** Clear takes precedence over count, which takes precedence over hold.
- **Clear (clrCounterIn=1).**
  - Digits, prescaler and overflowOut go to 0.
  - Lap state goes to LIVE.
  - tickOut=0.
  - enCounterIn and lapIn are ignored on that edge.
- **Count (enCounterIn=1, clrCounterIn=0).**
  - Prescaler width is max(1, $clog2(TICK_DIV)).
  - If prescaler < TICK_DIV-1, the prescaler increments.
  - Otherwise the prescaler goes to 0, the time increments by one hundredth and tickOut=1 for that cycle.
  - With TICK_DIV=1, every enabled cycle is a tick.
- **Hold (enCounterIn=0, clrCounterIn=0).** Prescaler and digits hold. The prescaler is not reset, so a pause/resume does not lose the partial tick. tickOut=0.
- **Digit cascade (BCD, decimal only).**
  - Each digit wraps at its limit: 9, or 5 for the tens of seconds and the tens of minutes.
  - A wrap carries into the next digit in the same cycle.
  - Digit values never leave their legal range.
- **Full wrap.** 59:59.99 plus one tick gives 00:00.00. overflowOut is set on that edge, and counting continues.
- **overflowOut.** Cleared only by clear or reset.

## Timing
- Outputs are registered, or a mux of registered values. There are no combinational paths from inputs to outputs.
- **Tick latency.** Ticks occur TICK_DIV enabled cycles apart.
  - The first tick after a clear comes TICK_DIV enabled edges after clear deasserts.
  - timeOut shows the new value in the same cycle that tickOut is high.
- **enCounterIn.** Takes effect on the first edge at which it is sampled high. Deasserting it stops the count on that edge.
- **clrCounterIn.** The FSM holds clear for one cycle. Holding it for N cycles keeps the block cleared for N cycles.
- **Reset mid-count.** Asynchronous zeroing of all state. Counting resumes only after rstIn deasserts and enCounterIn is sampled high.

## Configuration
- **STOPWATCH_LAP_EN defined.**
  - The lap register and state (LIVE/FROZEN) are built.
  - lapIn=1 in LIVE (no clear): captures the current registered time into the lap register and moves to FROZEN.
  - lapIn=1 in FROZEN: returns to LIVE.
  - In FROZEN, timeOut shows the lap register while the internal count, tickOut and overflowOut keep running.
  - If lapIn and a tick fall on the same edge, the captured value is the pre-increment time.
  - Clear or reset forces LIVE.
- **STOPWATCH_LAP_EN undefined.** No lap logic is built. lapIn is unused. timeOut always shows the live count.

## Test plan
- **Reset and basic count.** TICK_DIV=4. Reset, then enCounterIn=1 for 40 cycles -> tickOut pulses on cycles 4, 8, …, 40; timeOut=24'h000010 (00:00.10).
- **Pause retains the partial tick.** TICK_DIV=4. Enable 6 cycles, disable 10, enable 2 -> exactly 2 ticks; timeOut=24'h000002; no tick while paused.
- **Clear beats enable.** From 00:03.47, drive clrCounterIn=1 and enCounterIn=1 together for one edge -> timeOut=0, overflowOut=0. The next tick comes 4 enabled cycles later.
- **Cascade and wrap.** TICK_DIV=1. Preload by counting to 59:59.98 (24'h595998), then 2 more enabled cycles -> 59:59.99, then 00:00.00. overflowOut=1 from the wrap edge, and it stays 1 until clear.
- **Async reset mid-count.** Assert rstIn between clock edges while counting -> all outputs 0 before the next clkIn edge.
- **Lap freeze (STOPWATCH_LAP_EN).** TICK_DIV=1. Count to 24'h000025, pulse lapIn, count 10 more -> timeOut holds 24'h000025. Pulse lapIn again -> timeOut=24'h000035 (or later, by the number of enabled cycles).

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// Bundle of signals between the stopwatch control FSM and the timekeeping counter.
//   master : control side; drives enCounterIn, clrCounterIn and lapIn, and reads the results
//   slave  : counter side; reads the strobes and drives timeOut, tickOut and overflowOut
// Signals:
//   enCounterIn   count enable, level-sensitive
//   clrCounterIn  synchronous clear, level-sensitive
//   lapIn         one-cycle lap toggle pulse
//   timeOut       MM:SS.hh as six packed BCD digits
//   tickOut       one-cycle pulse for each hundredth increment
//   overflowOut   sticky flag for the wrap from 59:59.99 to 00:00.00
interface stopwatch_counter_if;
  logic        enCounterIn;
  logic        clrCounterIn;
  logic        lapIn;
  logic [23:0] timeOut;
  logic        tickOut;
  logic        overflowOut;

  modport master (
    output enCounterIn,
    output clrCounterIn,
    output lapIn,
    input  timeOut,
    input  tickOut,
    input  overflowOut
  );

  modport slave (
    input  enCounterIn,
    input  clrCounterIn,
    input  lapIn,
    output timeOut,
    output tickOut,
    output overflowOut
  );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping datapath. A prescaler divides clkIn down to hundredths of a second.
// The elapsed time is kept as six BCD digits (MM:SS.hh), which the digit cascade carries
// through.
// Ports:
//   clkIn  system clock; all state changes on its rising edge
//   rstIn  asynchronous, active-high reset
//   bus    stopwatch_counter_if.slave; carries the enable, clear and lap inputs and the
//          time, tick and overflow outputs
// Parameter:
//   TICK_DIV  clkIn cycles per hundredth of a second (>= 1)
// Build option:
//   STOPWATCH_LAP_EN  adds a lap register. While the lap state is FROZEN, timeOut shows the
//   captured time and the live count keeps running.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input logic                clkIn,
  input logic                rstIn,
  stopwatch_counter_if.slave bus
);

  localparam int unsigned    PreW    = ($clog2(TICK_DIV) > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic [23:0]     cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            ovf_q, ovf_d;

  // BCD increment of the live count. A carry out of the top digit means a full wrap.
  logic [23:0] cnt_inc;
  logic        full_wrap;
  logic        carry;
  logic [3:0]  lim;

  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    lim     = 4'd9;
    for (int i = 0; i < 6; i++) begin
      // Digits 3 and 5 are the tens of seconds and the tens of minutes.
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        // Using >= pulls any out-of-range digit back to 0.
        if (cnt_q[i*4 +: 4] >= lim) begin
          cnt_inc[i*4 +: 4] = 4'd0;
        end else begin
          cnt_inc[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    full_wrap = carry;
  end

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    ovf_d  = ovf_q;
    if (bus.clrCounterIn) begin
      pre_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (bus.enCounterIn) begin
      // The prescaler counts from 0 to PreLast and never goes above it.
      if (pre_q != PreLast) begin
        pre_d = pre_q + PreW'(1);
      end else begin
        pre_d  = '0;
        cnt_d  = cnt_inc;
        tick_d = 1'b1;
        if (full_wrap) begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.tickOut     = tick_q;
  assign bus.overflowOut = ovf_q;

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [0:0] {StLive, StFrozen} lap_state_e;

  lap_state_e  lap_state_q, lap_state_d;
  logic [23:0] lap_q, lap_d;

  always_comb begin
    lap_state_d = lap_state_q;
    lap_d       = lap_q;
    if (bus.clrCounterIn) begin
      lap_state_d = StLive;
      lap_d       = '0;
    end else if (bus.lapIn) begin
      unique case (lap_state_q)
        StLive: begin
          // cnt_q is the registered value from before this edge's tick.
          lap_d       = cnt_q;
          lap_state_d = StFrozen;
        end
        StFrozen: lap_state_d = StLive;
        default:  lap_state_d = StLive;
      endcase
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      lap_state_q <= StLive;
      lap_q       <= '0;
    end else begin
      lap_state_q <= lap_state_d;
      lap_q       <= lap_d;
    end
  end

  assign bus.timeOut = (lap_state_q == StFrozen) ? lap_q : cnt_q;
`else
  logic unused_lap;
  assign unused_lap  = bus.lapIn;
  assign bus.timeOut = cnt_q;
`endif

endmodule
